// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sound_pkg
//  Description : Shared definitions for the sound generator: sequencer state
//                encoding, clkgen maxval constants for the musical notes at a
//                10 MHz clock, and the default sample-rate divider.
//  Contents    : state_t, ST_IDLE/ST_FETCH/ST_PLAY, NOTE_* constants,
//                FS_DIV_DEFAULT, cnt_width()
//  Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_PLAY  = 2'd2;

   // clkgen maxval values for a 10 MHz clock
   localparam int NOTE_D     = 266;
   localparam int NOTE_E     = 237;
   localparam int NOTE_FIS   = 211;
   localparam int NOTE_G     = 199;
   localparam int NOTE_A     = 177;
   localparam int NOTE_B     = 158;
   localparam int NOTE_C     = 149;
   localparam int NOTE_DHIGH = 133;

   // 10 MHz / 125 = 80 kHz sample rate
   localparam int FS_DIV_DEFAULT = 125;

   // Counter width for a modulo-n counter; never zero so a divide-by-1 still
   // yields a legal vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/score_ram.sv
`default_nettype none
// ============================================================================
//  Module      : score_ram
//  Description : Score memory, DEPTH x WIDTH. One synchronous write port and
//                one registered read port. A read and a write to the same
//                address in the same cycle return the old contents.
//  Ports       : clk               - clock
//                wr_en/wr_addr/wr_data - write port
//                rd_addr           - read address (sampled every cycle)
//                rd_data           - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module score_ram #(
   parameter int DEPTH  = 32,
   parameter int WIDTH  = 22,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : melody_sequencer
//  Description : Programmable note sequencer. Plays a writable score of
//                {pitch, duration} entries, emitting the clkgen maxval and a
//                note-start pulse, with start/stop/loop control and an
//                optional silent gap at the end of each note.
//  Ports       : clk, reset           - clock, sync active-high reset
//                wr_en/wr_addr/wr_pitch/wr_dur - score write port
//                len                  - notes to play, sampled on start
//                start, stop, loop    - playback control
//                pitch                - current maxval (0 = silence)
//                note_start           - pulse on first PLAY cycle of a note
//                busy, done           - activity / completion pulse
//                note_idx             - index of the current note
//  Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer
   import sound_pkg::*;
#(
   parameter int PITCH_BITWIDTH = 9,
   parameter int DUR_BITWIDTH   = 13,
   parameter int DEPTH          = 32,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int FS_DIV         = FS_DIV_DEFAULT,
   parameter int GAP_SAMPLES    = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
   input  logic [DUR_BITWIDTH-1:0]   wr_dur,
   input  logic [ADDR_W:0]           len,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      loop,
   output logic [PITCH_BITWIDTH-1:0] pitch,
   output logic                      note_start,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_W-1:0]         note_idx
);

   localparam int                      SAMP_W    = cnt_width(FS_DIV);
   localparam logic [SAMP_W-1:0]       SAMP_LAST = SAMP_W'(FS_DIV - 1);
   localparam logic [DUR_BITWIDTH-1:0] GAP       = DUR_BITWIDTH'(GAP_SAMPLES);
   localparam logic [DUR_BITWIDTH-1:0] DUR_ONE   = DUR_BITWIDTH'(1);
   localparam logic [ADDR_W:0]         DEPTH_L   = (ADDR_W + 1)'(DEPTH);
   localparam int                      ENTRY_W   = PITCH_BITWIDTH + DUR_BITWIDTH;

   state_t                    state;
   logic [ADDR_W:0]           len_q;
   logic [DUR_BITWIDTH-1:0]   dur_q;
   logic [DUR_BITWIDTH-1:0]   tick_ctr;
   logic [SAMP_W-1:0]         samp_ctr;
   logic [PITCH_BITWIDTH-1:0] note_pitch;

   logic [ADDR_W-1:0]         rd_addr;
   logic [ENTRY_W-1:0]        rd_data;
   logic [PITCH_BITWIDTH-1:0] ent_pitch;
   logic [DUR_BITWIDTH-1:0]   ent_dur;

   logic                      tick;
   logic                      last_tick;
   logic                      more_notes;
   logic [DUR_BITWIDTH-1:0]   tick_nxt;
   logic                      gap_nxt;

   assign ent_pitch = rd_data[ENTRY_W-1:DUR_BITWIDTH];
   assign ent_dur   = rd_data[DUR_BITWIDTH-1:0];

   assign tick       = (samp_ctr == SAMP_LAST);
   assign last_tick  = (state == ST_PLAY) && tick && (tick_ctr == dur_q - DUR_ONE);
   assign more_notes = (({1'b0, note_idx} + 1'b1) < len_q);

   // The read for the next note is issued in the final PLAY cycle so the
   // registered RAM output is ready in FETCH. Looping and the IDLE start
   // both read entry 0.
   assign rd_addr = (last_tick && more_notes) ? (note_idx + 1'b1) : '0;

   // Gap decision is made on the tick count that will hold next cycle, so
   // pitch drops exactly on the first gap sample.
   assign tick_nxt = tick ? (tick_ctr + DUR_ONE) : tick_ctr;
   assign gap_nxt  = (GAP_SAMPLES > 0) && (dur_q > GAP) && (tick_nxt >= dur_q - GAP);

   assign busy = (state != ST_IDLE);

   score_ram #(
      .DEPTH  (DEPTH),
      .WIDTH  (ENTRY_W),
      .ADDR_W (ADDR_W)
   ) u_score_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data ({wr_pitch, wr_dur}),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         len_q      <= '0;
         dur_q      <= '0;
         tick_ctr   <= '0;
         samp_ctr   <= '0;
         note_pitch <= '0;
         pitch      <= '0;
         note_start <= 1'b0;
         done       <= 1'b0;
         note_idx   <= '0;
      end else if (stop) begin
         state      <= ST_IDLE;
         tick_ctr   <= '0;
         samp_ctr   <= '0;
         pitch      <= '0;
         note_start <= 1'b0;
         done       <= 1'b0;
         note_idx   <= '0;
      end else begin
         note_start <= 1'b0;
         done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && (len != '0)) begin
                  len_q    <= (len > DEPTH_L) ? DEPTH_L : len;
                  note_idx <= '0;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               dur_q      <= (ent_dur == '0) ? DUR_ONE : ent_dur;
               note_pitch <= ent_pitch;
               pitch      <= ent_pitch;
               note_start <= 1'b1;
               samp_ctr   <= '0;
               tick_ctr   <= '0;
               state      <= ST_PLAY;
            end
            ST_PLAY: begin
               if (tick) begin
                  samp_ctr <= '0;
                  if (last_tick) begin
                     tick_ctr <= '0;
                     if (more_notes) begin
                        note_idx <= note_idx + 1'b1;
                        state    <= ST_FETCH;
                     end else if (loop) begin
                        note_idx <= '0;
                        state    <= ST_FETCH;
                     end else begin
                        pitch <= '0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                     end
                  end else begin
                     tick_ctr <= tick_nxt;
                     pitch    <= gap_nxt ? '0 : note_pitch;
                  end
               end else begin
                  samp_ctr <= samp_ctr + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_melody_sequencer
//  Description : Self-checking bench for melody_sequencer. Expected notes are
//                queued when a song is started and popped on each note_start.
//                A second instance with a one-sample gap shares the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;
   import sound_pkg::*;

   localparam int PW    = 9;
   localparam int DW    = 13;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int FS    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [PW-1:0] wr_pitch;
   logic [DW-1:0] wr_dur;
   logic [AW:0]   len;
   logic          start;
   logic          stop;
   logic          loop;

   logic [PW-1:0] pitch_0, pitch_g;
   logic          ns_0, ns_g, busy_0, busy_g, done_0, done_g;
   logic [AW-1:0] idx_0, idx_g;

   melody_sequencer #(
      .PITCH_BITWIDTH (PW), .DUR_BITWIDTH (DW), .DEPTH (DEPTH),
      .FS_DIV (FS), .GAP_SAMPLES (0)
   ) dut (
      .clk (clk), .reset (reset), .wr_en (wr_en), .wr_addr (wr_addr),
      .wr_pitch (wr_pitch), .wr_dur (wr_dur), .len (len), .start (start),
      .stop (stop), .loop (loop), .pitch (pitch_0), .note_start (ns_0),
      .busy (busy_0), .done (done_0), .note_idx (idx_0)
   );

   melody_sequencer #(
      .PITCH_BITWIDTH (PW), .DUR_BITWIDTH (DW), .DEPTH (DEPTH),
      .FS_DIV (FS), .GAP_SAMPLES (1)
   ) dut_gap (
      .clk (clk), .reset (reset), .wr_en (wr_en), .wr_addr (wr_addr),
      .wr_pitch (wr_pitch), .wr_dur (wr_dur), .len (len), .start (start),
      .stop (stop), .loop (loop), .pitch (pitch_g), .note_start (ns_g),
      .busy (busy_g), .done (done_g), .note_idx (idx_g)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit use_gap = 1'b0;
   int o_pitch, o_idx;
   bit o_ns, o_busy, o_done;
   always_comb begin
      o_pitch = use_gap ? int'(pitch_g) : int'(pitch_0);
      o_idx   = use_gap ? int'(idx_g)   : int'(idx_0);
      o_ns    = use_gap ? ns_g   : ns_0;
      o_busy  = use_gap ? busy_g : busy_0;
      o_done  = use_gap ? done_g : done_0;
   end

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   typedef struct {
      int pitch;
      int idx;
      int dur;
   } note_t;
   note_t exp_q[$];

   int next_ns, end_cyc, cur_start, cur_dur, cur_pitch, song_s;

   task automatic push_note(input int p, input int i, input int d);
      note_t e;
      e.pitch = p;
      e.idx   = i;
      e.dur   = (d == 0) ? 1 : d;
      exp_q.push_back(e);
   endtask

   task automatic write_entry(input int a, input int p, input int d);
      @(negedge clk);
      wr_en    = 1'b1;
      wr_addr  = AW'(a);
      wr_pitch = PW'(p);
      wr_dur   = DW'(d);
      @(negedge clk);
      wr_en    = 1'b0;
   endtask

   // Drives start for one cycle; returns at the FETCH cycle.
   task automatic start_song(input int l);
      @(negedge clk);
      len     = (AW + 1)'(l);
      start   = 1'b1;
      song_s  = cyc;
      next_ns = cyc + 2;
      @(negedge clk);
      start = 1'b0;
      chk("busy_fetch", o_busy, 1);
   endtask

   function automatic int exp_pitch_now();
      int gap;
      int tk;
      gap = use_gap ? 1 : 0;
      tk  = (cyc - cur_start) / FS;
      if (gap > 0 && cur_dur > gap && tk >= cur_dur - gap) return 0;
      return cur_pitch;
   endfunction

   // Follows n notes; returns at the cycle after the n-th note's last PLAY cycle.
   task automatic observe(input int n, input bit want_done);
      int    seen;
      note_t e;
      seen = 0;
      for (int g = 0; g < 600; g++) begin
         @(negedge clk);
         if (o_ns) begin
            if (exp_q.size() == 0) begin
               chk("extra_note", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("ns_cycle", cyc, next_ns);
               chk("pitch_start", o_pitch, e.pitch);
               chk("note_idx", o_idx, e.idx);
               cur_start = cyc;
               cur_dur   = e.dur;
               cur_pitch = e.pitch;
               end_cyc   = cyc + e.dur * FS;
               next_ns   = end_cyc + 1;
               seen++;
            end
         end else if (seen > 0 && cyc < end_cyc) begin
            chk("pitch_play", o_pitch, exp_pitch_now());
         end
         if (o_done) chk("done_cycle", cyc, (want_done && seen == n) ? end_cyc : -1);
         if (seen == n && cyc == end_cyc) begin
            chk("done_end", o_done, want_done);
            chk("busy_end", o_busy, !want_done);
            return;
         end
      end
      chk("timeout", 0, 1);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_pitch"}, o_pitch, 0);
      chk({tag, "_ns"},    o_ns,    0);
      chk({tag, "_busy"},  o_busy,  0);
      chk({tag, "_done"},  o_done,  0);
      chk({tag, "_idx"},   o_idx,   0);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_pitch = '0; wr_dur = '0;
      len = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      reset = 1'b0;

      // 1: basic three-note song, no loop
      write_entry(0, NOTE_D, 2);
      write_entry(1, NOTE_G, 1);
      write_entry(2, NOTE_A, 3);
      push_note(NOTE_D, 0, 2); push_note(NOTE_G, 1, 1); push_note(NOTE_A, 2, 3);
      start_song(3);
      observe(3, 1'b1);
      chk("t1_done_at", end_cyc - song_s, 28);

      // 2: loop back to entry 0, then drop loop inside the second pass
      loop = 1'b1;
      push_note(NOTE_D, 0, 2); push_note(NOTE_G, 1, 1); push_note(NOTE_A, 2, 3);
      push_note(NOTE_D, 0, 2);
      start_song(3);
      observe(4, 1'b0);
      loop = 1'b0;
      push_note(NOTE_G, 1, 1); push_note(NOTE_A, 2, 3);
      observe(2, 1'b1);

      // 3: articulation gap on the GAP_SAMPLES=1 instance
      use_gap = 1'b1;
      write_entry(0, NOTE_G, 3);
      write_entry(1, NOTE_B, 1);
      push_note(NOTE_G, 0, 3); push_note(NOTE_B, 1, 1);
      start_song(2);
      observe(2, 1'b1);
      use_gap = 1'b0;

      // 4: stop mid-note, then start+stop together from IDLE
      write_entry(0, NOTE_D, 2);
      write_entry(1, NOTE_G, 1);
      write_entry(2, NOTE_A, 3);
      push_note(NOTE_D, 0, 2);
      start_song(3);
      observe(1, 1'b0);
      @(negedge clk);
      chk("stop_ns2", o_ns, 1);
      chk("stop_pitch2", o_pitch, NOTE_G);
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk_idle_outputs("stop");
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("stop_no_done", o_done, 0);
      end
      @(negedge clk);
      len = 4'd3; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", o_busy, 0);
      @(negedge clk);
      chk("startstop_busy2", o_busy, 0);
      chk("startstop_ns", o_ns, 0);

      // 5: len=0 ignored; len>DEPTH clamps; dur=0 plays one tick; start while busy
      @(negedge clk);
      len = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("len0_busy", o_busy, 0);
         @(negedge clk);
      end
      begin
         int pt [8];
         int du [8];
         pt = '{NOTE_D, NOTE_E, NOTE_FIS, NOTE_G, NOTE_A, NOTE_B, NOTE_C, NOTE_DHIGH};
         du = '{1, 1, 2, 0, 1, 1, 1, 1};
         for (int k = 0; k < 8; k++) begin
            write_entry(k, pt[k], du[k]);
            push_note(pt[k], k, du[k]);
         end
      end
      start_song(15);
      observe(2, 1'b0);
      len = 4'd1; start = 1'b1;
      fork
         observe(6, 1'b1);
         begin
            @(negedge clk);
            start = 1'b0;
         end
      join

      // 6: write racing the read of entry 1; new value on the next pass
      loop = 1'b1;
      write_entry(0, NOTE_D, 2);
      write_entry(1, NOTE_G, 1);
      push_note(NOTE_D, 0, 2); push_note(NOTE_G, 1, 1);
      push_note(NOTE_D, 0, 2); push_note(NOTE_FIS, 1, 1);
      start_song(2);
      fork
         observe(4, 1'b0);
         begin
            repeat (8) @(negedge clk);
            chk("race_align", cyc, song_s + 9);
            wr_en = 1'b1; wr_addr = 3'd1; wr_pitch = PW'(NOTE_FIS); wr_dur = DW'(1);
            @(negedge clk);
            wr_en = 1'b0;
         end
      join
      repeat (3) @(negedge clk);
      chk("pre_reset_busy", o_busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_idle_outputs("reset_mid");
      loop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_reset_busy", o_busy, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
